// File: rtl/dec_fault_pkg.sv
// Shared widths and default fault configuration for the faulty 4-to-16 decoder.
package dec_fault_pkg;

   localparam int unsigned DEC_IN_W   = 4;
   localparam int unsigned DEC_OUT_W  = 16;
   localparam int unsigned HALF_W     = 8;
   localparam int unsigned HALF_SEL_W = 3;

   // Default injected fault: low-half line 2 stuck-at-0
   localparam int unsigned FAULT_LINE_DEF = 2;
   localparam logic        FAULT_VAL_DEF  = 1'b0;

endpackage : dec_fault_pkg

// File: rtl/dec_3x8.sv
// Combinational 3-to-8 one-hot decoder with enable.
module dec_3x8
   import dec_fault_pkg::*;
(
   input  logic [HALF_SEL_W-1:0] a,
   input  logic                  en,
   output logic [HALF_W-1:0]     y
);

   // One-hot decode of a, gated by enable
   always_comb begin
      y = '0;
      if (en) begin
         y = HALF_W'(1) << a;
      end
   end

endmodule : dec_3x8

// File: rtl/dec_4x16_fault2.sv
// Registered 4-to-16 decoder built from two 3-to-8 halves, with one low-half
// line stuck at FAULT_VAL. Define DEC_FAULT_DETECT_EN to add a golden decode
// path and the registered fault_det mismatch flag.
module dec_4x16_fault2
   import dec_fault_pkg::*;
#(
   parameter int unsigned FAULT_LINE = FAULT_LINE_DEF,
   parameter logic        FAULT_VAL  = FAULT_VAL_DEF
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 X,
   input  logic                 Y,
   input  logic                 Z,
   input  logic                 W,
`ifdef DEC_FAULT_DETECT_EN
   output logic                 fault_det,
`endif
   output logic [DEC_OUT_W-1:0] D
);

   logic [DEC_IN_W-1:0]  sel;
   logic                 en_lo;
   logic                 en_hi;
   logic [HALF_W-1:0]    lo;
   logic [HALF_W-1:0]    hi;
   logic [HALF_W-1:0]    lo_f;
   logic [DEC_OUT_W-1:0] d_d;
   logic [DEC_OUT_W-1:0] d_q;

   assign sel   = {X, Y, Z, W};
   assign en_lo = en & ~sel[DEC_IN_W-1];
   assign en_hi = en &  sel[DEC_IN_W-1];

   dec_3x8 u_dec_lo (
      .a  (sel[HALF_SEL_W-1:0]),
      .en (en_lo),
      .y  (lo)
   );

   dec_3x8 u_dec_hi (
      .a  (sel[HALF_SEL_W-1:0]),
      .en (en_hi),
      .y  (hi)
   );

   // Replace the faulty low-half line with its stuck value
   always_comb begin
      lo_f = lo;
      lo_f[HALF_SEL_W'(FAULT_LINE)] = FAULT_VAL;
      d_d  = {hi, lo_f};
   end

   // Output register stage
   always_ff @(posedge clk) begin
      if (rst) begin
         d_q <= '0;
      end else begin
         d_q <= d_d;
      end
   end

   assign D = d_q;

`ifdef DEC_FAULT_DETECT_EN
   logic [HALF_W-1:0]    lo_gold;
   logic [DEC_OUT_W-1:0] ideal;
   logic                 fault_det_d;
   logic                 fault_det_q;

   dec_3x8 u_dec_gold_lo (
      .a  (sel[HALF_SEL_W-1:0]),
      .en (en_lo),
      .y  (lo_gold)
   );

   // Golden code differs from the faulty one only in the low half
   always_comb begin
      ideal       = {hi, lo_gold};
      fault_det_d = |(ideal ^ d_d);
   end

   // Mismatch flag aligned with D
   always_ff @(posedge clk) begin
      if (rst) begin
         fault_det_q <= 1'b0;
      end else begin
         fault_det_q <= fault_det_d;
      end
   end

   assign fault_det = fault_det_q;
`endif

endmodule : dec_4x16_fault2

// File: tb/tb_dec_4x16_fault2.sv
// Self-checking bench: stuck-at-0 and stuck-at-1 instances against an
// arithmetic reference decoder, directed cases then random traffic.
module tb_dec_4x16_fault2;

   localparam int unsigned TB_FAULT_LINE = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        X, Y, Z, W;
   logic [15:0] d_sa0;
   logic [15:0] d_sa1;
   logic        fd_sa0;
   logic        fd_sa1;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   dec_4x16_fault2 #(.FAULT_LINE(TB_FAULT_LINE), .FAULT_VAL(1'b0)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .X         (X),
      .Y         (Y),
      .Z         (Z),
      .W         (W),
`ifdef DEC_FAULT_DETECT_EN
      .fault_det (fd_sa0),
`endif
      .D         (d_sa0)
   );

   dec_4x16_fault2 #(.FAULT_LINE(TB_FAULT_LINE), .FAULT_VAL(1'b1)) dut_sa1 (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .X         (X),
      .Y         (Y),
      .Z         (Z),
      .W         (W),
`ifdef DEC_FAULT_DETECT_EN
      .fault_det (fd_sa1),
`endif
      .D         (d_sa1)
   );

`ifndef DEC_FAULT_DETECT_EN
   assign fd_sa0 = 1'b0;
   assign fd_sa1 = 1'b0;
`endif

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 16'h%04h, expected 16'h%04h", tag, got, exp);
      end
   endtask

   // Ideal decoder value from plain arithmetic
   function automatic int ideal_code(input logic r, input logic e, input int s);
      if (r) return 0;
      return e ? (1 << s) : 0;
   endfunction

   // Faulty decoder: ideal code with the fault line forced to fv
   function automatic int faulty_code(input logic r, input logic e, input int s, input int fv);
      int v;
      if (r) return 0;
      v = ideal_code(r, e, s);
      if (fv != 0) v = v | (1 << TB_FAULT_LINE);
      else         v = v & ~(1 << TB_FAULT_LINE);
      return v;
   endfunction

   // Apply one input vector, then check both instances one edge later
   task automatic step(input string tag, input logic r, input logic e, input logic [3:0] s);
      int e0, e1, id;
      rst = r;
      en  = e;
      {X, Y, Z, W} = s;
      @(posedge clk);
      #1;
      id = ideal_code(r, e, int'(s));
      e0 = faulty_code(r, e, int'(s), 0);
      e1 = faulty_code(r, e, int'(s), 1);
      check({tag, "/sa0"}, d_sa0, 16'(e0));
      check({tag, "/sa1"}, d_sa1, 16'(e1));
`ifdef DEC_FAULT_DETECT_EN
      check({tag, "/det0"}, 16'(fd_sa0), 16'((!r && e0 != id) ? 1 : 0));
      check({tag, "/det1"}, 16'(fd_sa1), 16'((!r && e1 != id) ? 1 : 0));
`endif
   endtask

   initial begin
      rst = 1'b1;
      en  = 1'b1;
      {X, Y, Z, W} = 4'hF;
      #1;

      // Reset held two cycles with active inputs
      step("rst0", 1'b1, 1'b1, 4'hF);
      step("rst1", 1'b1, 1'b1, 4'hF);

      // Full sweep with enable
      for (int i = 0; i < 16; i++) step($sformatf("sweep%0d", i), 1'b0, 1'b1, 4'(i));

      // Directed constants from the fault description
      step("sel2", 1'b0, 1'b1, 4'h2);
      check("sel2_const", d_sa0, 16'h0000);
      step("sa1_en", 1'b0, 1'b1, 4'h5);
      check("sa1_en_const", d_sa1, 16'h0024);
      step("sa1_dis", 1'b0, 1'b0, 4'h5);
      check("sa1_dis_const", d_sa1, 16'h0004);

      // Disabled decoder
      step("dis2", 1'b0, 1'b0, 4'h2);
      step("dis9", 1'b0, 1'b0, 4'h9);
      check("dis9_const", d_sa0, 16'h0000);

      // Back-to-back selects
      step("b2b8", 1'b0, 1'b1, 4'h8);
      check("b2b8_const", d_sa0, 16'h0100);
      step("b2b7", 1'b0, 1'b1, 4'h7);
      check("b2b7_const", d_sa0, 16'h0080);
      step("b2bA", 1'b0, 1'b1, 4'hA);
      check("b2bA_const", d_sa0, 16'h0400);

      // Reset mid-sweep, then resume
      step("mid_b", 1'b0, 1'b1, 4'hB);
      step("mid_rst", 1'b1, 1'b1, 4'hC);
      check("mid_rst_const", d_sa1, 16'h0000);
      step("mid_c", 1'b0, 1'b1, 4'hC);
      check("mid_c_const", d_sa0, 16'h1000);
      step("mid_d", 1'b0, 1'b1, 4'hD);

      // Random traffic with occasional reset
      for (int n = 0; n < 300; n++) begin
         step($sformatf("rnd%0d", n),
              1'($urandom_range(0, 15) == 0),
              1'($urandom_range(0, 3) != 0),
              4'($urandom_range(0, 15)));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_dec_4x16_fault2
